// File: rtl/pix_scan_if.sv
// Output beat bus of the raster coordinate generator: valid/ready handshake
// plus the beat payload (lane-0 x, row y, per-lane mask, row/frame markers).
interface pix_scan_if #(
  parameter int NUM_X_BITS = 10,
  parameter int NUM_Y_BITS = 10,
  parameter int LANES      = 4
);
  logic                  out_valid;
  logic                  out_ready;
  logic [NUM_X_BITS-1:0] x_value;
  logic [NUM_Y_BITS-1:0] y_value;
  logic [LANES-1:0]      lane_mask;
  logic                  row_last;
  logic                  frame_last;

  modport master (
    output out_valid, x_value, y_value, lane_mask, row_last, frame_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, x_value, y_value, lane_mask, row_last, frame_last,
    output out_ready
  );
endinterface

// File: rtl/pix_scan_gen.sv
// Raster coordinate generator: scans a (x_max+1) x (y_max+1) frame and emits
// LANES horizontally adjacent pixels per beat over a valid/ready bus.
// Optional feature macro: PIX_SCAN_SERPENTINE_EN (odd rows scan right-to-left).
module pix_scan_gen #(
  parameter int NUM_X_BITS = 10,
  parameter int NUM_Y_BITS = 10,
  parameter int LANES      = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic [NUM_X_BITS-1:0] x_max,
  input  logic [NUM_Y_BITS-1:0] y_max,
  output logic                  busy,
  output logic                  done,
  pix_scan_if.master            bus
);

  // One extra bit so x + LANES never wraps when x_max is all-ones.
  localparam int XW1 = NUM_X_BITS + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [NUM_X_BITS-1:0] x_r;
  logic [NUM_Y_BITS-1:0] y_r;
  logic [NUM_X_BITS-1:0] x_max_r;
  logic [NUM_Y_BITS-1:0] y_max_r;
  logic [NUM_X_BITS-1:0] x_nxt_s;
  logic [NUM_Y_BITS-1:0] y_nxt_s;
  logic [XW1-1:0]        x_ext_s;
  logic [XW1-1:0]        x_max_ext_s;
  logic [XW1-1:0]        x_end_s;
  logic [LANES-1:0]      mask_s;
  logic                  row_last_s;
  logic                  frame_last_s;
  logic                  hs_s;

  assign x_ext_s      = {1'b0, x_r};
  assign x_max_ext_s  = {1'b0, x_max_r};
  assign x_end_s      = x_ext_s + XW1'(LANES);
  assign frame_last_s = row_last_s & (y_r == y_max_r);
  assign hs_s         = (state_r == ST_RUN) & bus.out_ready;
  assign bus.x_value  = x_r;
  assign bus.y_value  = y_r;

`ifdef PIX_SCAN_SERPENTINE_EN
  localparam logic [NUM_X_BITS-1:0] LANE_LOW_MASK = NUM_X_BITS'(LANES - 1);

  logic                  odd_row_s;
  logic [NUM_X_BITS-1:0] rev_base_s;

  assign odd_row_s  = y_r[0];
  // Lane-0 x of the rightmost beat of a row: x_max rounded down to a LANES multiple.
  assign rev_base_s = x_max_r & ~LANE_LOW_MASK;

  // Row end detection and beat-to-beat coordinate stepping in both scan directions.
  always_comb begin
    row_last_s = 1'b0;
    x_nxt_s    = x_r;
    y_nxt_s    = y_r;
    if (odd_row_s) begin
      row_last_s = (x_r == {NUM_X_BITS{1'b0}});
    end else begin
      row_last_s = (x_end_s > x_max_ext_s);
    end
    if (row_last_s) begin
      y_nxt_s = y_r + {{(NUM_Y_BITS-1){1'b0}}, 1'b1};
      if (odd_row_s) begin
        x_nxt_s = {NUM_X_BITS{1'b0}};
      end else begin
        x_nxt_s = rev_base_s;
      end
    end else begin
      if (odd_row_s) begin
        x_nxt_s = x_r - NUM_X_BITS'(LANES);
      end else begin
        x_nxt_s = x_r + NUM_X_BITS'(LANES);
      end
    end
  end
`else
  // Row end detection and left-to-right coordinate stepping.
  always_comb begin
    row_last_s = (x_end_s > x_max_ext_s);
    x_nxt_s    = x_r;
    y_nxt_s    = y_r;
    if (row_last_s) begin
      x_nxt_s = {NUM_X_BITS{1'b0}};
      y_nxt_s = y_r + {{(NUM_Y_BITS-1){1'b0}}, 1'b1};
    end else begin
      x_nxt_s = x_r + NUM_X_BITS'(LANES);
    end
  end
`endif

  // Per-lane validity: lane i is real iff x_value + i stays within x_max.
  always_comb begin
    mask_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      mask_s[i] = ((x_ext_s + XW1'(i)) <= x_max_ext_s);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; clear wins over start and over the handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clear) begin
          state_nxt_s = ST_IDLE;
        end else if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_nxt_s = ST_IDLE;
        end else if (hs_s && frame_last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs; payload markers are forced low outside RUN.
  always_comb begin
    bus.out_valid  = 1'b0;
    bus.lane_mask  = {LANES{1'b0}};
    bus.row_last   = 1'b0;
    bus.frame_last = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state_r)
      ST_RUN: begin
        bus.out_valid  = 1'b1;
        bus.lane_mask  = mask_s;
        bus.row_last   = row_last_s;
        bus.frame_last = frame_last_s;
        busy           = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  // Coordinate and frame-limit registers; limits are captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      x_r     <= {NUM_X_BITS{1'b0}};
      y_r     <= {NUM_Y_BITS{1'b0}};
      x_max_r <= {NUM_X_BITS{1'b0}};
      y_max_r <= {NUM_Y_BITS{1'b0}};
    end else if (clear) begin
      x_r <= {NUM_X_BITS{1'b0}};
      y_r <= {NUM_Y_BITS{1'b0}};
    end else if ((state_r == ST_IDLE) && start) begin
      x_r     <= {NUM_X_BITS{1'b0}};
      y_r     <= {NUM_Y_BITS{1'b0}};
      x_max_r <= x_max;
      y_max_r <= y_max;
    end else if (hs_s && !frame_last_s) begin
      x_r <= x_nxt_s;
      y_r <= y_nxt_s;
    end else begin
      x_r <= x_r;
      y_r <= y_r;
    end
  end

endmodule

// File: tb/tb_pix_scan_gen.sv
// Scoreboard bench for pix_scan_gen: stimulus pushes expected beats, a
// negedge monitor compares every presented beat (stalled or accepted).
module tb_pix_scan_gen;

  localparam int XW = 10;
  localparam int YW = 10;
  localparam int LN = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic          clear;
  logic [XW-1:0] x_max;
  logic [YW-1:0] y_max;
  logic          busy;
  logic          done;

  pix_scan_if #(.NUM_X_BITS(XW), .NUM_Y_BITS(YW), .LANES(LN)) bus ();

  pix_scan_gen #(.NUM_X_BITS(XW), .NUM_Y_BITS(YW), .LANES(LN)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .start (start),
    .clear (clear),
    .x_max (x_max),
    .y_max (y_max),
    .busy  (busy),
    .done  (done),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [LN-1:0] m;
    logic          rl;
    logic          fl;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int    n_vec      = 0;
  int    n_err      = 0;
  int    cyc        = 0;
  int    hs_cnt     = 0;
  int    hs_neg_cyc = -10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented beat must match the queue head; pop on acceptance.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && bus.out_valid === 1'b1) begin
      mon_b = {bus.x_value, bus.y_value, bus.lane_mask, bus.row_last, bus.frame_last};
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {6'd0, mon_b}, 32'hFFFF_FFFF);
      end else if (bus.out_ready === 1'b1) begin
        check("beat", {6'd0, mon_b}, {6'd0, exp_q[0]});
        void'(exp_q.pop_front());
        hs_cnt++;
        hs_neg_cyc = cyc;
      end else begin
        check("stall_hold", {6'd0, mon_b}, {6'd0, exp_q[0]});
      end
    end
  end

  // Reference beat list for a frame (serpentine order when the feature is built in).
  task automatic push_frame(input int xm, input int ym);
    int    nb;
    int    x;
    beat_t b;
    nb = xm / LN + 1;
    for (int y = 0; y <= ym; y++) begin
      for (int k = 0; k < nb; k++) begin
        x = k * LN;
`ifdef PIX_SCAN_SERPENTINE_EN
        if ((y % 2) == 1) x = (nb - 1 - k) * LN;
`endif
        b.x = XW'(x);
        b.y = YW'(y);
        for (int i = 0; i < LN; i++) b.m[i] = ((x + i) <= xm);
        b.rl = (k == nb - 1);
        b.fl = (k == nb - 1) && (y == ym);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int xm, input int ym, input logic [3:0] rpat, input string tag);
    int hs0;
    int nb;
    int idx;
    int waited;
    bit seen;
    nb  = (ym + 1) * (xm / LN + 1);
    push_frame(xm, ym);
    hs0 = hs_cnt;
    x_max = XW'(xm);
    y_max = YW'(ym);
    start = 1'b1;
    bus.out_ready = rpat[0];
    idx = 1;
    tick();
    start = 1'b0;
    x_max = '0;
    y_max = '0;
    @(negedge clk);
    check({tag, "_valid_after_start"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < 3000) begin
      tick();
      bus.out_ready = rpat[idx % 4];
      idx++;
      @(negedge clk);
      waited++;
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      check({tag, "_done_latency"}, cyc - hs_neg_cyc, 32'd1);
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      check({tag, "_valid_at_done"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, "_beat_count"}, hs_cnt - hs0, nb);
      check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
      tick();
      @(negedge clk);
      check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    end else begin
      exp_q.delete();
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int dn;
    n_rst = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    x_max = '0;
    y_max = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mask", {28'd0, bus.lane_mask}, 32'd0);
    check("rst_xy", {12'd0, bus.x_value, bus.y_value}, 32'd0);
    check("rst_last", {30'd0, bus.row_last, bus.frame_last}, 32'd0);
    tick();
    n_rst = 1'b1;
    tick();

    run_frame(7, 1, 4'b1111, "f7x1");
    run_frame(5, 0, 4'b1111, "f5x0");
    run_frame(0, 0, 4'b1111, "f0x0");
    run_frame(7, 1, 4'b1001, "stall");
    run_frame(1023, 0, 4'b1111, "wide");

    // Abort mid-frame, with a start pulse during RUN that must be ignored.
    push_frame(7, 1);
    x_max = 10'd7;
    y_max = 10'd1;
    bus.out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    x_max = 10'd3;
    y_max = 10'd0;
    bus.out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clear = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("clr_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    tick();
    clear = 1'b0;
    @(negedge clk);
    check("clr_valid", {31'd0, bus.out_valid}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_done", {31'd0, done}, 32'd0);
    check("clr_remaining", exp_q.size(), 32'd2);
    exp_q.delete();
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    check("clr_no_done", dn, 32'd0);
    run_frame(3, 0, 4'b1111, "restart");

    run_frame(9, 1, 4'b1111, "f9x1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
